// File: rtl/fifo_pkg.sv
// Shared definitions for sync_fifo and its read-side consumers.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    StRun,
    StFlushWait
  } pack_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port: dout is valid the cycle after rd_en && !empty.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = 64,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] dout_q;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      if (wr_en && !full) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (rd_en && !empty) begin
        rptr_q <= rptr_q + 1'b1;
        dout_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains sync_fifo entries and packs NBYTES of them (first in LSBs) into one valid/ready word,
// with a flush request that emits a zero-padded partial word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned NBYTES     = 4,
  localparam int unsigned OUT_W     = DATA_WIDTH * NBYTES,
  localparam int unsigned CNT_W     = cnt_w(NBYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic [OUT_W-1:0]      out_data,
  output logic [CNT_W-1:0]      out_bytes,
  output logic                  out_valid,
  input  logic                  out_ready
);

  pack_state_e      state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d, acc_cap;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d, cnt_cap;
  logic             rd_pend_q;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_bytes_q, out_bytes_d;
  logic             out_valid_q, out_valid_d;
  logic             flush_pend, out_free, full_go, part_go, handoff;

  always_comb begin
    // View of the accumulator after this cycle's capture, used by both hand-off and read issue.
    cnt_cap = byte_cnt_q + CNT_W'(rd_pend_q);
    acc_cap = acc_q;
    for (int k = 0; k < NBYTES; k++) begin
      if (rd_pend_q && (byte_cnt_q == CNT_W'(k))) begin
        acc_cap[k*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
      end
    end

    flush_pend = (state_q == StFlushWait);
    out_free   = !out_valid_q || out_ready;
    full_go    = (cnt_cap == CNT_W'(NBYTES)) && out_free;
    part_go    = flush_pend && !rd_pend_q && (byte_cnt_q != '0) && out_free;
    handoff    = full_go || part_go;
    byte_cnt_d = handoff ? '0 : cnt_cap;
    acc_d      = handoff ? '0 : acc_cap;

    // A hand-off frees the slots this cycle, so reading continues at one entry per clock.
    fifo_rd_en = !fifo_empty && !flush_pend && (byte_cnt_d < CNT_W'(NBYTES));

    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    out_valid_d = out_valid_q;
    if (handoff) begin
      out_data_d  = acc_cap;
      out_bytes_d = cnt_cap;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (flush) begin
          state_d = StFlushWait;
        end
      end
      StFlushWait: begin
        if (!rd_pend_q && ((byte_cnt_q == '0) || out_free)) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      acc_q       <= '0;
      byte_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      byte_cnt_q  <= byte_cnt_d;
      rd_pend_q   <= fifo_rd_en;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign out_valid = out_valid_q;

endmodule
